// File: rtl/rep_13_pkg.sv
// Shared constants and types for the rep_13 magnitude comparator.
// Latency: n/a. Backpressure: n/a.
// Result bit positions are shared by the datapath, the optional counters and the bench.
package rep_13_pkg;

    localparam int X_GT  = 2;
    localparam int X_EQ  = 1;
    localparam int X_LT  = 0;
    localparam int CNT_W = 16;

    typedef logic [2:0] res_t;

endpackage

// File: rtl/rep_13_slice.sv
// One-bit compare cell: refines the gt/eq/lt state cascaded from the more significant bits.
// Latency: combinational. Backpressure: none.
// INV swaps the bit sense, which turns the sign bit of a two's-complement operand into a compare.
module rep_13_slice #(
    parameter bit INV = 1'b0
) (
    input  logic a_i,
    input  logic b_i,
    input  logic gt_i,
    input  logic eq_i,
    input  logic lt_i,
    output logic gt_o,
    output logic eq_o,
    output logic lt_o
);

    logic a_hi;
    logic b_hi;

    // A set sign bit marks the smaller operand, so the MSB slice reads the bits swapped.
    assign a_hi = INV ? (~a_i & b_i) : (a_i & ~b_i);
    assign b_hi = INV ? (a_i & ~b_i) : (~a_i & b_i);

    assign gt_o = gt_i | (eq_i & a_hi);
    assign lt_o = lt_i | (eq_i & b_hi);
    assign eq_o = eq_i & ~(a_i ^ b_i);

endmodule

// File: rtl/rep_13.sv
// Registered one-hot compare of a and b (x = {gt, eq, lt}); optional REP_13_STATS_EN adds saturating result counters.
// Latency: 1 cycle from in_valid to out_valid, one result per cycle.
// Backpressure: none; x holds its last value while in_valid is low.
module rep_13
    import rep_13_pkg::*;
#(
    parameter int W      = 2,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
`ifdef REP_13_STATS_EN
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_lt,
`endif
    output logic [2:0]       x,
    output logic             out_valid
);

    logic [W:0] gt_c;
    logic [W:0] eq_c;
    logic [W:0] lt_c;

    // The cascade starts at the MSB in the "equal so far" state.
    assign gt_c[W] = 1'b0;
    assign eq_c[W] = 1'b1;
    assign lt_c[W] = 1'b0;

    for (genvar i = W - 1; i >= 0; i--) begin : g_slice
        rep_13_slice #(
            .INV ((SIGNED != 0) && (i == W - 1))
        ) u_slice (
            .a_i  (a[i]),
            .b_i  (b[i]),
            .gt_i (gt_c[i+1]),
            .eq_i (eq_c[i+1]),
            .lt_i (lt_c[i+1]),
            .gt_o (gt_c[i]),
            .eq_o (eq_c[i]),
            .lt_o (lt_c[i])
        );
    end

    res_t res;
    res_t x_d, x_q;
    logic out_valid_d, out_valid_q;

    always_comb begin
        res        = '0;
        res[X_GT]  = gt_c[0];
        res[X_EQ]  = eq_c[0];
        res[X_LT]  = lt_c[0];
        x_d        = in_valid ? res : x_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign x         = x_q;
    assign out_valid = out_valid_q;

`ifdef REP_13_STATS_EN
    // Counter k tracks result bit k, so the array index matches the X_* constants.
    logic [CNT_W-1:0] cnt_d [3];
    logic [CNT_W-1:0] cnt_q [3];

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            cnt_d[k] = cnt_q[k];
            if (out_valid_q && x_q[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign cnt_gt = cnt_q[X_GT];
    assign cnt_eq = cnt_q[X_EQ];
    assign cnt_lt = cnt_q[X_LT];
`endif

endmodule

// File: tb/tb_rep_13.sv
// Directed bench for rep_13: unsigned W=2, signed W=2 and signed W=1 instances driven in lockstep.
module tb_rep_13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] a = '0;
    logic [1:0] b = '0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;

    logic [2:0] x_u, x_s, x_1;
    logic       ov_u, ov_s, ov_1;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

`ifdef REP_13_STATS_EN
    logic [15:0] gt_u, eq_u, lt_u, gt_s, eq_s, lt_s, gt_1, eq_1, lt_1;
`endif

    rep_13 #(.W(2), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
`ifdef REP_13_STATS_EN
        .cnt_gt(gt_u), .cnt_eq(eq_u), .cnt_lt(lt_u),
`endif
        .x(x_u), .out_valid(ov_u)
    );

    rep_13 #(.W(2), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
`ifdef REP_13_STATS_EN
        .cnt_gt(gt_s), .cnt_eq(eq_s), .cnt_lt(lt_s),
`endif
        .x(x_s), .out_valid(ov_s)
    );

    rep_13 #(.W(1), .SIGNED(1)) u_dut_1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
`ifdef REP_13_STATS_EN
        .cnt_gt(gt_1), .cnt_eq(eq_1), .cnt_lt(lt_1),
`endif
        .x(x_1), .out_valid(ov_1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Directed table: {a, b, x unsigned, x signed}, values worked out by hand.
    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] xu;
        logic [2:0] xs;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{a: 2'd3, b: 2'd0, xu: 3'b100, xs: 3'b001};
        vecs[1] = '{a: 2'd3, b: 2'd1, xu: 3'b100, xs: 3'b001};
        vecs[2] = '{a: 2'd2, b: 2'd1, xu: 3'b100, xs: 3'b001};
        vecs[3] = '{a: 2'd1, b: 2'd2, xu: 3'b001, xs: 3'b100};
        vecs[4] = '{a: 2'd2, b: 2'd3, xu: 3'b001, xs: 3'b001};
        vecs[5] = '{a: 2'd3, b: 2'd2, xu: 3'b100, xs: 3'b100};
        vecs[6] = '{a: 2'd0, b: 2'd3, xu: 3'b001, xs: 3'b100};
        vecs[7] = '{a: 2'd1, b: 2'd1, xu: 3'b010, xs: 3'b010};
        vecs[8] = '{a: 2'd0, b: 2'd1, xu: 3'b001, xs: 3'b001};
        vecs[9] = '{a: 2'd2, b: 2'd2, xu: 3'b010, xs: 3'b010};
    end

    logic [1:0] seq_a  [4];
    logic [1:0] seq_b  [4];
    logic [2:0] seq_x  [4];
    logic [0:0] w1_a   [3];
    logic [0:0] w1_b   [3];
    logic [2:0] w1_x   [3];

    initial begin
        seq_a = '{2'd3, 2'd0, 2'd1, 2'd0};
        seq_b = '{2'd3, 2'd0, 2'd2, 2'd3};
        seq_x = '{3'b010, 3'b010, 3'b001, 3'b001};
        // W=1 signed: 1 is -1.
        w1_a = '{1'b1, 1'b0, 1'b1};
        w1_b = '{1'b0, 1'b1, 1'b1};
        w1_x = '{3'b001, 3'b100, 3'b010};
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_x_u", x_u, 3'b000);
        chk("rst_ov_u", ov_u, 1'b0);
        chk("rst_x_s", x_s, 3'b000);
        rst = 1'b0;

        // Single unsigned/signed result with 1-cycle latency.
        a = 2'd3; b = 2'd0; in_valid = 1'b1;
        @(negedge clk);
        chk("first_x_u", x_u, 3'b100);
        chk("first_ov_u", ov_u, 1'b1);
        chk("first_x_s", x_s, 3'b001);

        // Back-to-back sequence, no bubbles.
        for (int i = 0; i < 4; i++) begin
            a = seq_a[i]; b = seq_b[i]; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("seq%0d_x", i), x_u, seq_x[i]);
            chk($sformatf("seq%0d_ov", i), ov_u, 1'b1);
        end

        for (int i = 0; i < 10; i++) begin
            a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_u", i), x_u, vecs[i].xu);
            chk($sformatf("vec%0d_s", i), x_s, vecs[i].xs);
        end

        for (int i = 0; i < 3; i++) begin
            a1 = w1_a[i]; b1 = w1_b[i]; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("w1_%0d_x", i), x_1, w1_x[i]);
            chk($sformatf("w1_%0d_ov", i), ov_1, 1'b1);
        end

        // Hold: x keeps the (2,1) result while in_valid is low.
        a = 2'd2; b = 2'd1; in_valid = 1'b1;
        @(negedge clk);
        chk("hold_load", x_u, 3'b100);
        a = 2'd0; b = 2'd3; in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_x", i), x_u, 3'b100);
            chk($sformatf("hold%0d_ov", i), ov_u, 1'b0);
        end

        // Asynchronous reset mid-stream, checked between clock edges.
        a = 2'd1; b = 2'd2; in_valid = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_rst_x", x_u, 3'b001);
        rst = 1'b1;
        #1;
        chk("async_rst_x", x_u, 3'b000);
        chk("async_rst_ov", ov_u, 1'b0);
        chk("async_rst_x_s", x_s, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        a = 2'd3; b = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_x", i), x_u, 3'b000);
            chk($sformatf("post_rst%0d_ov", i), ov_u, 1'b0);
        end

        // First valid after reset.
        a = 2'd0; b = 2'd0; in_valid = 1'b1;
        @(negedge clk);
        chk("after_rst_x", x_u, 3'b010);
        chk("after_rst_ov", ov_u, 1'b1);
        in_valid = 1'b0;

`ifdef REP_13_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("cnt_rst_eq", eq_u, 16'h0000);
        a = 2'd1; b = 2'd1; in_valid = 1'b1;
        repeat (70000) @(negedge clk);
        chk("cnt_eq_sat", eq_u, 16'hFFFF);
        chk("cnt_gt_zero", gt_u, 16'h0000);
        chk("cnt_lt_zero", lt_u, 16'h0000);
        in_valid = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/rep_13.md
REP_13 -- requirements
Module: rep_13

Interface
REQ-001 Parameter W, default 2; bit width of operands a and b; legal range 1..32.
REQ-002 Parameter SIGNED, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  operands a/b valid this cycle.
REQ-006 a  input  W  first operand.
REQ-007 b  input  W  second operand.
REQ-008 x  output  3  registered compare result, one-hot: x[2] = a>b, x[1] = a==b, x[0] = a<b.
REQ-009 out_valid  output  1  x updated in the previous cycle from a valid input.

Function
REQ-010 On a rising clk edge with in_valid=1, x SHALL load the one-hot result for the sampled a, b.
REQ-011 Latency SHALL be exactly 1 cycle; out_valid SHALL equal in_valid delayed by one cycle.
REQ-012 With in_valid=0, x SHALL hold its previous value and out_valid SHALL be 0 the next cycle.
REQ-013 Outside reset, exactly one bit of x SHALL be set after the first valid input.
REQ-014 SIGNED=0: operands compare as unsigned integers (a=2'b11 > b=2'b01).
REQ-015 SIGNED=1: operands compare as two's complement (a=2'b11 (-1) < b=2'b01 (+1)).
REQ-016 Comparison SHALL be an MSB-to-LSB cascade. Signed mode inverts the MSB-slice sense. No arithmetic subtraction carry.
REQ-017 Back-to-back valid inputs SHALL give one result per cycle with no bubbles.
REQ-018 W=1 SHALL be supported. With W=1 and SIGNED=1, 1'b1 = -1.

Reset
REQ-019 While rst=1: x = 3'b000, out_valid = 0. All optional counters = 0, independent of clk.
REQ-020 Reset asserted mid-stream SHALL discard any result in flight.
REQ-021 The first valid input after rst deasserts SHALL produce a result one cycle later.

Configuration
REQ-022 Macro REP_13_STATS_EN compiled in: three 16-bit saturating output counters are added: cnt_gt, cnt_eq, cnt_lt.
- Each counter increments on every cycle where out_valid=1 and its x bit is set.
- Each counter saturates at 16'hFFFF.
REQ-023 Macro REP_13_STATS_EN absent: counter ports and logic SHALL not exist; all other behaviour is identical.

Structure
REQ-024 Package rep_13_pkg SHALL hold:
- bit-index constants X_GT=2, X_EQ=1, X_LT=0;
- a typedef for the 3-bit result;
- the counter width constant (16).
REQ-025 Sub-module rep_13_slice: a one-bit compare cell.
- Inputs: a_i, b_i, and the cascaded gt/eq/lt from the higher bits.
- Outputs: updated gt/eq/lt.
- rep_13 instantiates W slices.

Verification
REQ-026 W=2, SIGNED=0; a=2'b11, b=2'b00, in_valid=1 -> next cycle x=3'b100, out_valid=1.
REQ-027 W=2, SIGNED=0; sequence (3,3), (0,0), (1,2), (0,3) on consecutive cycles -> x = 010, 010, 001, 001 on the following cycles, no bubbles.
REQ-028 W=2, SIGNED=1; a=2'b11, b=2'b01 -> x=3'b001. Same operands with SIGNED=0 -> x=3'b100.
REQ-029 Reset test:
- rst=1 asynchronously mid-stream -> x=000 and out_valid=0 immediately, without a clk edge.
- After release, in_valid=0 for 3 cycles -> x stays 000.
REQ-030 Hold test: in_valid=0 after a (2,1) result -> x stays 3'b100 and out_valid=0.
REQ-031 With REP_13_STATS_EN: apply 70000 equal-operand valid cycles -> cnt_eq=16'hFFFF (saturated), cnt_gt=cnt_lt=0.
